rst_req_gen: RTL and testbench
==============================

Name: rst_req_gen

Overview:
Generates the active-high reset request that drives the asynchronous reset input of the board-level reset synchronizer. It takes a raw, bouncing pushbutton and a synchronous software request. It synchronizes and debounces the button, then emits one fixed-width reset pulse per press. A holdoff window and a release interlock prevent repeated pulses. It also counts issued requests for debug readout.

Parameters:
SYNC_STAGES, 2, number of flops in the btn_in synchronizer chain (>=2)
DB_CYCLES, 16, consecutive high samples of synchronized button required to accept a press (>=1)
PULSE_LEN, 8, width of rst_req pulse in clk cycles (>=1)
HOLDOFF, 32, cycles after pulse during which all requests are ignored (>=1)
CNT_W, 8, width of req_count

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-low
btn_in  input  1  raw pushbutton, asynchronous to clk, active-high, may bounce
sw_req  input  1  synchronous single-cycle software reset request, active-high
rst_req  output  1  registered reset request, active-high, exactly PULSE_LEN cycles wide
busy  output  1  high whenever the FSM is not in IDLE
req_count  output  CNT_W  number of pulses issued, saturating

Behaviour:
- rst low (asynchronous, no clock needed): synchronizer flops = 0, FSM = IDLE, internal counter = 0, rst_req = 0, busy = 0, req_count = 0. Deassertion takes effect at the next clk edge.
- btn_in passes through SYNC_STAGES flops to give btn_s. Only btn_s is used by the FSM.
- Single down-counter, sized to the largest of DB_CYCLES, PULSE_LEN and HOLDOFF, shared by all states.
- FSM states: IDLE, DEBOUNCE, PULSE, HOLDOFF, WAIT_RELEASE.
  - IDLE:
    - sw_req=1 -> PULSE, cnt = PULSE_LEN-1. sw_req wins if btn_s=1 in the same cycle.
    - else btn_s=1 -> DEBOUNCE, cnt = DB_CYCLES-1.
  - DEBOUNCE:
    - btn_s=0 -> IDLE (glitch rejected, no count change).
    - btn_s=1 and cnt=0 -> PULSE, cnt = PULSE_LEN-1.
    - otherwise cnt decrements.
    - sw_req is ignored in this state.
  - PULSE:
    - cnt=0 -> HOLDOFF, cnt = HOLDOFF-1; otherwise cnt decrements.
    - btn_s and sw_req are ignored.
  - HOLDOFF: cnt=0 -> WAIT_RELEASE; otherwise cnt decrements. All inputs are ignored.
  - WAIT_RELEASE: btn_s=0 -> IDLE; otherwise hold. sw_req is ignored.
- Outputs are Moore and registered:
  - rst_req = (state==PULSE), so it is high for exactly PULSE_LEN consecutive cycles.
  - busy = (state!=IDLE).
- req_count increments by 1 on the edge that enters PULSE. It saturates at 2^CNT_W-1 and never wraps.
- Latency, counting edges from edge 0 (the first edge at which btn_in=1 is sampled), with btn held high:
  - btn_s = 1 after edge SYNC_STAGES-1.
  - DEBOUNCE is entered at edge SYNC_STAGES.
  - PULSE (rst_req=1) is entered at edge SYNC_STAGES+DB_CYCLES. With defaults this is edge 18.
- sw_req sampled in IDLE at edge k: rst_req=1 after edge k and falls after edge k+PULSE_LEN.
- Requests arriving while busy are dropped, not queued.
- A held button yields exactly one pulse. A new press requires btn_s=0 (reaching IDLE) and then a fresh debounce.
- Reset mid-operation: rst_req drops asynchronously and any pulse in progress is abandoned, not resumed.

Test Plan:
1. rst=0 with btn_in=1 and sw_req=1 -> rst_req=0, busy=0, req_count=0. Release rst with btn_in=0 for 20 cycles -> outputs stay 0.
2. btn_in=1 held 80 cycles (defaults):
   - busy rises after edge 2.
   - rst_req high after edges 18..25 only (8 cycles).
   - req_count=1 and no second pulse while the button is held.
   - After btn_in=0, busy falls SYNC_STAGES+1 edges later.
3. btn_in high 10 cycles then low (bounce), repeated 3 times -> rst_req never asserts, req_count=0, FSM returns to IDLE each time.
4. sw_req pulse at edge 5 with btn_in=0:
   - rst_req high after edges 5..12.
   - A further sw_req at edge 9 and at edge 30 (HOLDOFF) is ignored; req_count=1.
   - busy falls after edge 46 (8+32+1 cycles after entry).
5. Drive rst low asynchronously midway through PULSE, between clock edges -> rst_req and busy fall with no clk edge, req_count=0. After release, a new sw_req gives a full 8-cycle pulse.
6. CNT_W=2: issue 5 well-spaced sw_req pulses -> req_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/rst_req_gen.sv
// rst_req_gen: turns a bouncing pushbutton or a one-cycle software request into a single
// fixed-width, active-high reset request pulse, followed by a holdoff window and a
// release interlock. Also keeps a saturating count of issued pulses for debug.
module rst_req_gen #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 16,
    parameter int unsigned PULSE_LEN   = 8,
    parameter int unsigned HOLDOFF     = 32,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    input  logic             sw_req,
    output logic             rst_req,
    output logic             busy,
    output logic [CNT_W-1:0] req_count
);

    // One down-counter is shared by every timed state, so size it for the longest interval.
    localparam int unsigned MaxDbPulse = (DB_CYCLES > PULSE_LEN) ? DB_CYCLES : PULSE_LEN;
    localparam int unsigned CntMax     = (MaxDbPulse > HOLDOFF) ? MaxDbPulse : HOLDOFF;
    localparam int unsigned CntBits    = $clog2(CntMax + 1);

    localparam logic [CntBits-1:0] DbLoad    = CntBits'(DB_CYCLES - 1);
    localparam logic [CntBits-1:0] PulseLoad = CntBits'(PULSE_LEN - 1);
    localparam logic [CntBits-1:0] HoldLoad  = CntBits'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDebounce,
        StPulse,
        StHoldoff,
        StWaitRelease
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [CntBits-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]       req_count_q, req_count_d;
    logic                   rst_req_q, rst_req_d;
    logic                   busy_q, busy_d;
    logic                   btn_s;
    logic                   enter_pulse;

    assign btn_s = sync_q[SYNC_STAGES-1];

    // Shift the raw button into the synchronizer chain; bit 0 is the first stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
    end

    // Next-state and counter logic; inputs not listed for a state are deliberately ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (sw_req) begin
                    state_d = StPulse;
                    cnt_d   = PulseLoad;
                end else if (btn_s) begin
                    state_d = StDebounce;
                    cnt_d   = DbLoad;
                end
            end
            StDebounce: begin
                if (!btn_s) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StPulse;
                    cnt_d   = PulseLoad;
                end else begin
                    cnt_d = cnt_q - CntBits'(1);
                end
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    state_d = StHoldoff;
                    cnt_d   = HoldLoad;
                end else begin
                    cnt_d = cnt_q - CntBits'(1);
                end
            end
            StHoldoff: begin
                if (cnt_q == '0) begin
                    state_d = StWaitRelease;
                end else begin
                    cnt_d = cnt_q - CntBits'(1);
                end
            end
            StWaitRelease: begin
                // A held button must be let go before another press can be debounced.
                if (!btn_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore outputs decoded from the next state so they register alongside the state.
    always_comb begin
        enter_pulse = (state_d == StPulse) && (state_q != StPulse);
        rst_req_d   = (state_d == StPulse);
        busy_d      = (state_d != StIdle);
        req_count_d = req_count_q;
        if (enter_pulse && (req_count_q != {CNT_W{1'b1}})) begin
            req_count_d = req_count_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low clear; an in-flight pulse is abandoned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= '0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            req_count_q <= '0;
            rst_req_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_count_q <= req_count_d;
            rst_req_q   <= rst_req_d;
            busy_q      <= busy_d;
        end
    end

    assign rst_req   = rst_req_q;
    assign busy      = busy_q;
    assign req_count = req_count_q;

endmodule

// File: tb/tb_rst_req_gen.sv
// tb_rst_req_gen: directed stimulus for rst_req_gen, checked every cycle against a
// timestamp-based model of the request rules, plus literal expectations at key edges.
module tb_rst_req_gen;

    localparam int unsigned SS = 2;
    localparam int unsigned DB = 16;
    localparam int unsigned PL = 8;
    localparam int unsigned HO = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;
    logic       sw_req = 1'b0;
    logic       rst_req, busy, rst_req2, busy2;
    logic [7:0] req_count;
    logic [1:0] req_count2;

    int n_cmp = 0;
    int n_bad = 0;

    rst_req_gen u_dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .sw_req   (sw_req),
        .rst_req  (rst_req),
        .busy     (busy),
        .req_count(req_count)
    );

    rst_req_gen #(.CNT_W(2)) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .sw_req   (sw_req),
        .rst_req  (rst_req2),
        .busy     (busy2),
        .req_count(req_count2)
    );

    always #5 clk = ~clk;

    // Model: remembers when the current press/pulse started and derives outputs by arithmetic.
    int mcyc = 0;       // completed edges out of reset; next edge index is mcyc
    int pulse_at = -1;  // edge at which the current pulse started
    int db_at = -1;     // edge at which the current debounce started
    int n_pulses = 0;
    int m_e;
    bit m_bs;
    bit bq[$];          // btn_in samples, newest first

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse_at = -1;
            db_at    = -1;
            n_pulses = 0;
            bq.delete();
            for (int i = 0; i < SS; i++) bq.push_back(1'b0);
        end else begin
            m_e  = mcyc;
            m_bs = bq[SS-1];
            if (pulse_at >= 0) begin
                if (m_e > pulse_at + PL + HO && !m_bs) pulse_at = -1;
            end else if (db_at >= 0) begin
                if (!m_bs) begin
                    db_at = -1;
                end else if (m_e == db_at + DB) begin
                    pulse_at = m_e;
                    db_at    = -1;
                    n_pulses++;
                end
            end else if (sw_req) begin
                pulse_at = m_e;
                n_pulses++;
            end else if (m_bs) begin
                db_at = m_e;
            end
            bq.push_front(btn_in);
            void'(bq.pop_back());
            mcyc++;
        end
    end

    function automatic int sat(input int n, input int m);
        return (n > m) ? m : n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the clock edge.
    always @(posedge clk) begin
        #2;
        chk("cyc_rst_req", int'(rst_req),
            int'(pulse_at >= 0 && (mcyc - 1) < pulse_at + int'(PL)));
        chk("cyc_busy", int'(busy), int'(pulse_at >= 0 || db_at >= 0));
        chk("cyc_count", int'(req_count), sat(n_pulses, 255));
        chk("cyc_count2", int'(req_count2), sat(n_pulses, 3));
    end

    int base = 0;

    task automatic mark();
        base = mcyc;
    endtask

    // Return just after edge k (relative to the last mark) has been taken.
    task automatic to_edge(input int k);
        while (mcyc < base + k + 1) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_sw();
        @(negedge clk);
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b0;
        btn_in = 1'b0;
        sw_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int exp2[5] = '{1, 2, 3, 3, 3};

    initial begin
        // 1: reset dominates active inputs, then idle with button released
        #1;
        rst    = 1'b0;
        btn_in = 1'b1;
        sw_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rst_req", int'(rst_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(req_count), 0);
        btn_in = 1'b0;
        sw_req = 1'b0;
        rst    = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_rst_req", int'(rst_req), 0);

        // 2: held button -> one pulse at edges 18..25
        mark();
        btn_in = 1'b1;
        to_edge(1);  chk("btn_busy_e1", int'(busy), 0);
        to_edge(2);  chk("btn_busy_e2", int'(busy), 1);
        to_edge(17); chk("btn_req_e17", int'(rst_req), 0);
        to_edge(18); chk("btn_req_e18", int'(rst_req), 1);
        chk("btn_count_e18", int'(req_count), 1);
        to_edge(25); chk("btn_req_e25", int'(rst_req), 1);
        to_edge(26); chk("btn_req_e26", int'(rst_req), 0);
        to_edge(79); chk("btn_held_busy", int'(busy), 1);
        chk("btn_held_count", int'(req_count), 1);
        @(negedge clk);
        btn_in = 1'b0;
        to_edge(81); chk("rel_busy_e81", int'(busy), 1);
        to_edge(82); chk("rel_busy_e82", int'(busy), 0);

        // 3: short bounces are rejected
        do_reset();
        for (int r = 0; r < 3; r++) begin
            mark();
            btn_in = 1'b1;
            to_edge(9);
            @(negedge clk);
            btn_in = 1'b0;
            to_edge(14);
            chk("bounce_busy", int'(busy), 0);
            chk("bounce_count", int'(req_count), 0);
        end

        // 4: software request, later requests dropped while busy
        do_reset();
        mark();
        to_edge(4);  chk("sw_req_e4", int'(rst_req), 0);
        pulse_sw();
        to_edge(5);  chk("sw_req_e5", int'(rst_req), 1);
        to_edge(8);
        pulse_sw();
        to_edge(12); chk("sw_req_e12", int'(rst_req), 1);
        to_edge(13); chk("sw_req_e13", int'(rst_req), 0);
        to_edge(29);
        pulse_sw();
        to_edge(45); chk("sw_busy_e45", int'(busy), 1);
        to_edge(46); chk("sw_busy_e46", int'(busy), 0);
        chk("sw_count", int'(req_count), 1);

        // 5: asynchronous reset in the middle of a pulse
        do_reset();
        mark();
        to_edge(1);
        pulse_sw();
        to_edge(5);  chk("mid_req_before", int'(rst_req), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_req", int'(rst_req), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_count", int'(req_count), 0);
        @(negedge clk);
        rst = 1'b1;
        mark();
        to_edge(2);
        pulse_sw();
        to_edge(3);  chk("post_req_e3", int'(rst_req), 1);
        to_edge(10); chk("post_req_e10", int'(rst_req), 1);
        to_edge(11); chk("post_req_e11", int'(rst_req), 0);
        chk("post_count", int'(req_count), 1);

        // 6: counter saturation on the narrow instance
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pulse_sw();
            repeat (50) @(negedge clk);
            chk("sat_count2", int'(req_count2), exp2[i]);
            chk("sat_count", int'(req_count), i + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
